alu_reservation_station: RTL

- Out-of-order reservation station for the ALU path; sits between the dispatcher and the arithmetic/logic unit.
- Buffers decoded ALU/branch/jump ops with operand values or ROB tags, and snoops the CDB to wake up waiting operands.
- Issues at most one ready entry per cycle to the ALU through registered outputs.

---
 rtl/alu_reservation_station.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_reservation_station.sv
// ALU reservation station: 2^RS_BIT entries with CDB wakeup and one registered issue per cycle.
// Optional RS_OLDEST_FIRST_EN: age-ranked oldest-ready-first issue instead of lowest-index-first.
`ifndef OP_W
`define OP_W 6
`endif
`ifndef ROB_BIT
`define ROB_BIT 4
`endif
`ifndef DAT_W
`define DAT_W 32
`endif
`ifndef RAM_ADR_W
`define RAM_ADR_W 16
`endif

module alu_reservation_station #(
    parameter int RS_BIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr_i,
    input  logic                  dsp_en_i,
    input  logic [`OP_W-1:0]      dsp_op_i,
    input  logic                  dsp_ic_i,
    input  logic [`ROB_BIT-1:0]   dsp_qd_i,
    input  logic                  dsp_rs_ok_i,
    input  logic                  dsp_rt_ok_i,
    input  logic [`DAT_W-1:0]     dsp_vs_i,
    input  logic [`DAT_W-1:0]     dsp_vt_i,
    input  logic [`ROB_BIT-1:0]   dsp_qs_i,
    input  logic [`ROB_BIT-1:0]   dsp_qt_i,
    input  logic [`DAT_W-1:0]     dsp_imm_i,
    input  logic [`RAM_ADR_W-1:0] dsp_pc_i,
    input  logic                  cdb_en_i,
    input  logic [`ROB_BIT-1:0]   cdb_q_i,
    input  logic [`DAT_W-1:0]     cdb_v_i,
    output logic                  full_o,
    output logic                  alu_en_o,
    output logic [`OP_W-1:0]      alu_op_o,
    output logic                  alu_ic_o,
    output logic [`ROB_BIT-1:0]   alu_qd_o,
    output logic [`DAT_W-1:0]     alu_vs_o,
    output logic [`DAT_W-1:0]     alu_vt_o,
    output logic [`DAT_W-1:0]     alu_imm_o,
    output logic [`RAM_ADR_W-1:0] alu_pc_o
);

    localparam int unsigned RS_N = 1 << RS_BIT;

    logic [RS_N-1:0]       busy;
    logic [RS_N-1:0]       s_ok;
    logic [RS_N-1:0]       t_ok;
    logic [RS_N-1:0]       ic;
    logic [`OP_W-1:0]      op  [RS_N];
    logic [`ROB_BIT-1:0]   qd  [RS_N];
    logic [`ROB_BIT-1:0]   qs  [RS_N];
    logic [`ROB_BIT-1:0]   qt  [RS_N];
    logic [`DAT_W-1:0]     vs  [RS_N];
    logic [`DAT_W-1:0]     vt  [RS_N];
    logic [`DAT_W-1:0]     imm [RS_N];
    logic [`RAM_ADR_W-1:0] pc  [RS_N];

    logic [RS_N-1:0]   ready;
    logic              free_any;
    logic [RS_BIT-1:0] free_idx;
    logic              iss_any;
    logic [RS_BIT-1:0] iss_idx;
    logic              dsp_go;
    logic              cap_s;
    logic              cap_t;

    assign full_o = &busy;
    assign ready  = busy & s_ok & t_ok;
    assign dsp_go = dsp_en_i && !full_o;
    assign cap_s  = !dsp_rs_ok_i && cdb_en_i && (cdb_q_i == dsp_qs_i);
    assign cap_t  = !dsp_rt_ok_i && cdb_en_i && (cdb_q_i == dsp_qt_i);

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < RS_N; i++) begin
            if (!busy[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = RS_BIT'(i);
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [RS_BIT:0] rank     [RS_N];
    logic [RS_BIT:0] rank_nxt [RS_N];
    logic [RS_BIT:0] best_rank;

    always_comb begin
        iss_any   = 1'b0;
        iss_idx   = '0;
        best_rank = '0;
        for (int unsigned i = 0; i < RS_N; i++) begin
            if (ready[i] && (!iss_any || rank[i] > best_rank)) begin
                iss_any   = 1'b1;
                iss_idx   = RS_BIT'(i);
                best_rank = rank[i];
            end
        end
    end

    // Older entries than the issued one close the gap; every survivor ages by one on dispatch.
    always_comb begin
        for (int unsigned i = 0; i < RS_N; i++) begin
            rank_nxt[i] = rank[i];
            if (dsp_go)
                rank_nxt[i] = rank_nxt[i] + 1'b1;
            if (iss_any && rank[i] > best_rank)
                rank_nxt[i] = rank_nxt[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_N; i++)
                rank[i] <= '0;
        end else if (!clr_i && en) begin
            for (int unsigned i = 0; i < RS_N; i++)
                if (busy[i])
                    rank[i] <= rank_nxt[i];
            if (dsp_go)
                rank[free_idx] <= '0;
        end
    end
`else
    always_comb begin
        iss_any = 1'b0;
        iss_idx = '0;
        for (int unsigned i = 0; i < RS_N; i++) begin
            if (ready[i] && !iss_any) begin
                iss_any = 1'b1;
                iss_idx = RS_BIT'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            alu_en_o  <= 1'b0;
            alu_op_o  <= '0;
            alu_ic_o  <= 1'b0;
            alu_qd_o  <= '0;
            alu_vs_o  <= '0;
            alu_vt_o  <= '0;
            alu_imm_o <= '0;
            alu_pc_o  <= '0;
        end else if (clr_i) begin
            busy      <= '0;
            alu_en_o  <= 1'b0;
            alu_op_o  <= '0;
            alu_ic_o  <= 1'b0;
            alu_qd_o  <= '0;
            alu_vs_o  <= '0;
            alu_vt_o  <= '0;
            alu_imm_o <= '0;
            alu_pc_o  <= '0;
        end else if (en) begin
            for (int unsigned i = 0; i < RS_N; i++) begin
                if (busy[i] && !s_ok[i] && cdb_en_i && qs[i] == cdb_q_i) begin
                    s_ok[i] <= 1'b1;
                    vs[i]   <= cdb_v_i;
                end
                if (busy[i] && !t_ok[i] && cdb_en_i && qt[i] == cdb_q_i) begin
                    t_ok[i] <= 1'b1;
                    vt[i]   <= cdb_v_i;
                end
            end

            if (iss_any) begin
                busy[iss_idx] <= 1'b0;
                alu_en_o      <= 1'b1;
                alu_op_o      <= op[iss_idx];
                alu_ic_o      <= ic[iss_idx];
                alu_qd_o      <= qd[iss_idx];
                alu_vs_o      <= vs[iss_idx];
                alu_vt_o      <= vt[iss_idx];
                alu_imm_o     <= imm[iss_idx];
                alu_pc_o      <= pc[iss_idx];
            end else begin
                alu_en_o  <= 1'b0;
                alu_op_o  <= '0;
                alu_ic_o  <= 1'b0;
                alu_qd_o  <= '0;
                alu_vs_o  <= '0;
                alu_vt_o  <= '0;
                alu_imm_o <= '0;
                alu_pc_o  <= '0;
            end

            // The free slot is never busy, so it cannot collide with wakeup or issue writes.
            if (dsp_go) begin
                busy[free_idx] <= 1'b1;
                op[free_idx]   <= dsp_op_i;
                ic[free_idx]   <= dsp_ic_i;
                qd[free_idx]   <= dsp_qd_i;
                qs[free_idx]   <= dsp_qs_i;
                qt[free_idx]   <= dsp_qt_i;
                imm[free_idx]  <= dsp_imm_i;
                pc[free_idx]   <= dsp_pc_i;
                s_ok[free_idx] <= dsp_rs_ok_i | cap_s;
                t_ok[free_idx] <= dsp_rt_ok_i | cap_t;
                vs[free_idx]   <= cap_s ? cdb_v_i : dsp_vs_i;
                vt[free_idx]   <= cap_t ? cdb_v_i : dsp_vt_i;
            end
        end
    end

endmodule
